// File: rtl/layer_sequencer.sv
// layer_sequencer: buffers one input vector, broadcasts it to a neuron bank,
// collects each neuron's activation and drains them as an indexed stream.
module layer_sequencer #(
    parameter  int NUM_INPUTS  = 128,
    parameter  int NUM_NEURONS = 8,
    parameter  int DATA_WIDTH  = 16,
    parameter  int OUT_WIDTH   = 16,
    parameter  int TIMEOUT     = 64,
    localparam int AW          = $clog2(NUM_INPUTS),
    localparam int IW          = $clog2(NUM_NEURONS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_wr_en,
    input  logic [AW-1:0]                    in_wr_addr,
    input  logic [DATA_WIDTH-1:0]            in_wr_data,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic                             timeout_err,
    output logic                             nrn_in_valid,
    output logic [DATA_WIDTH-1:0]            nrn_in_data,
    input  logic [NUM_NEURONS-1:0]           nrn_out_valid,
    input  logic [NUM_NEURONS*OUT_WIDTH-1:0] nrn_out_data,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [OUT_WIDTH-1:0]             res_data,
    output logic [IW-1:0]                    res_idx
);

    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(NUM_INPUTS);
    localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t                 state_q;
    logic [DATA_WIDTH-1:0]  ibuf_q [NUM_INPUTS];
    logic [CW-1:0]          word_q;
    logic [TW-1:0]          wait_q;
    logic [NUM_NEURONS-1:0] flag_q, flag_d;
    logic [OUT_WIDTH-1:0]   cap_q [NUM_NEURONS];
    logic [OUT_WIDTH-1:0]   cap_d [NUM_NEURONS];
    logic [IW-1:0]          nxt_idx;
    logic                   capturing;

    logic                   done_q;
    logic                   terr_q;
    logic                   in_valid_q;
    logic [DATA_WIDTH-1:0]  in_data_q;
    logic                   res_valid_q;
    logic [OUT_WIDTH-1:0]   res_data_q;
    logic [IW-1:0]          res_idx_q;

    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign timeout_err  = terr_q;
    assign nrn_in_valid = in_valid_q;
    assign nrn_in_data  = in_data_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_idx      = res_idx_q;

    // Only the first outvalid per neuron per run is kept.
    always_comb begin
        capturing = (state_q == S_STREAM) || (state_q == S_WAIT);
        flag_d    = flag_q;
        cap_d     = cap_q;
        nxt_idx   = res_idx_q + 1'b1;
        if (capturing) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (nrn_out_valid[i] && !flag_q[i]) begin
                    flag_d[i] = 1'b1;
                    cap_d[i]  = nrn_out_data[i*OUT_WIDTH +: OUT_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_wr_en && state_q == S_IDLE) begin
            ibuf_q[in_wr_addr] <= in_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            wait_q      <= '0;
            flag_q      <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) cap_q[i] <= '0;
            done_q      <= 1'b0;
            terr_q      <= 1'b0;
            in_valid_q  <= 1'b0;
            in_data_q   <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            flag_q <= flag_d;
            cap_q  <= cap_d;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        terr_q     <= 1'b0;
                        flag_q     <= '0;
                        for (int i = 0; i < NUM_NEURONS; i++) cap_q[i] <= '0;
                        in_valid_q <= 1'b1;
                        in_data_q  <= ibuf_q[0];
                        word_q     <= CW'(1);
                        state_q    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (word_q == LAST_WORD) begin
                        in_valid_q <= 1'b0;
                        in_data_q  <= '0;
                        wait_q     <= '0;
                        state_q    <= S_WAIT;
                    end else begin
                        in_data_q <= ibuf_q[word_q[AW-1:0]];
                        word_q    <= word_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    // Completion wins over a timeout on the same edge.
                    if (&flag_d || wait_q == LAST_WAIT) begin
                        terr_q      <= ~&flag_d;
                        res_valid_q <= 1'b1;
                        res_idx_q   <= '0;
                        res_data_q  <= cap_d[0];
                        state_q     <= S_DRAIN;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (res_ready) begin
                        if (res_idx_q == LAST_IDX) begin
                            res_valid_q <= 1'b0;
                            res_idx_q   <= '0;
                            res_data_q  <= '0;
                            done_q      <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            res_idx_q  <= nxt_idx;
                            res_data_q <= cap_q[nxt_idx];
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
